// File: rtl/therm_pkg.sv
// Shared constants and the clean-thermometer predicate for bin2therm consumers.
package therm_pkg;

   localparam int N = 8;
   localparam int W = 2 ** N;

   // A clean word is ones at bits 0..m and zeros above: word+1 is then a power of two (or wraps to 0).
   function automatic logic is_therm(input logic [W-1:0] word);
      logic [W-1:0] nxt;
      nxt = word + 1'b1;
      return word[0] & ((word & nxt) == '0);
   endfunction

endpackage

// File: rtl/therm_bubble_fix.sv
// Combinational 3-tap majority bubble correction plus malformed-word detection.
module therm_bubble_fix
   import therm_pkg::is_therm;
#(
   parameter int W = therm_pkg::W
) (
   input  logic [W-1:0] din,
   output logic [W-1:0] corrected,
   output logic         raw_err
);

   // Pad with an implied one below bit 0 and an implied zero above the top bit.
   logic [W+1:0] ext;
   assign ext = {1'b0, din, 1'b1};

   generate
      for (genvar gi = 0; gi < W; gi++) begin : g_maj
         assign corrected[gi] = (ext[gi] & ext[gi+1]) | (ext[gi] & ext[gi+2]) |
                                (ext[gi+1] & ext[gi+2]);
      end
   endgenerate

   assign raw_err = ~is_therm(din);

endmodule

// File: rtl/therm2bin_pipe.sv
// Two-stage thermometer-to-binary encoder with valid/ready flow control and a saturating error counter.
module therm2bin_pipe #(
   parameter int N      = therm_pkg::N,
   parameter int W      = 2 ** N,
   parameter int ECNT_W = 16
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [W-1:0]      din,
   input  logic              din_vld,
   output logic              din_rdy,
   output logic [N-1:0]      dout,
   output logic              dout_err,
   output logic              dout_vld,
   input  logic              dout_rdy,
   output logic [ECNT_W-1:0] err_cnt
);

   localparam logic [ECNT_W-1:0] CNT_MAX = '1;

   logic [W-1:0]      corrected;
   logic              raw_err;
   logic              s1_vld_reg;
   logic [W-1:0]      s1_word_reg;
   logic              s1_err_reg;
   logic [N-1:0]      dout_reg;
   logic              dout_err_reg;
   logic              dout_vld_reg;
   logic [ECNT_W-1:0] err_cnt_reg;
   logic [N-1:0]      enc;
   logic              s2_load;
   logic              din_acc;
   logic              out_xfer;

   therm_bubble_fix #(.W(W)) u_fix (
      .din       (din),
      .corrected (corrected),
      .raw_err   (raw_err)
   );

   assign out_xfer = dout_vld_reg & dout_rdy;
   assign s2_load  = s1_vld_reg & (~dout_vld_reg | dout_rdy);
   assign din_rdy  = ~s1_vld_reg | s2_load;
   assign din_acc  = din_vld & din_rdy;

   // Highest set bit wins; an all-zero corrected word encodes as 0.
   always_comb begin
      enc = '0;
      for (int i = 0; i < W; i++) begin
         if (s1_word_reg[i]) enc = N'(i);
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         s1_vld_reg  <= 1'b0;
         s1_word_reg <= '0;
         s1_err_reg  <= 1'b0;
      end else if (din_acc) begin
         s1_vld_reg  <= 1'b1;
         s1_word_reg <= corrected;
         s1_err_reg  <= raw_err;
      end else if (s2_load) begin
         s1_vld_reg  <= 1'b0;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         dout_vld_reg <= 1'b0;
         dout_reg     <= '0;
         dout_err_reg <= 1'b0;
      end else if (s2_load) begin
         dout_vld_reg <= 1'b1;
         dout_reg     <= enc;
         dout_err_reg <= s1_err_reg;
      end else if (out_xfer) begin
         dout_vld_reg <= 1'b0;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         err_cnt_reg <= '0;
      end else if (out_xfer && dout_err_reg && err_cnt_reg != CNT_MAX) begin
         err_cnt_reg <= err_cnt_reg + 1'b1;
      end
   end

   assign dout     = dout_reg;
   assign dout_err = dout_err_reg;
   assign dout_vld = dout_vld_reg;
   assign err_cnt  = err_cnt_reg;

endmodule

// File: tb/tb_therm2bin_pipe.sv
// Directed-vector bench for therm2bin_pipe: table-driven stream plus stall, reset and saturation sequences.
module tb_therm2bin_pipe;
   import therm_pkg::*;

   typedef struct {
      logic [W-1:0] din;
      int           dout;
      int           err;
      bit           chk_lat;
      bit           chk_gap;
      int           acc_cyc;
   } vec_t;

   logic         clk;
   logic         reset;
   logic [W-1:0] din;
   logic         din_vld;
   logic         din_rdy;
   logic [7:0]   dout;
   logic         dout_err;
   logic         dout_vld;
   logic         dout_rdy;
   logic [15:0]  err_cnt;

   logic [W-1:0] din2;
   logic         din2_vld;
   logic         din2_rdy;
   logic [7:0]   dout2;
   logic         dout2_err;
   logic         dout2_vld;
   logic         dout2_rdy;
   logic [1:0]   err_cnt2;

   int   nvec = 0;
   int   nmis = 0;
   int   ncyc = 0;
   int   last_out = 0;
   int   acc_cnt = 0;
   int   exp_cnt = 0;
   vec_t tx_q[$];
   vec_t exp_q[$];
   vec_t sb_e;
   vec_t tbl[7];

   therm2bin_pipe #(.N(8), .ECNT_W(16)) dut (
      .clk(clk), .reset(reset), .din(din), .din_vld(din_vld), .din_rdy(din_rdy),
      .dout(dout), .dout_err(dout_err), .dout_vld(dout_vld), .dout_rdy(dout_rdy),
      .err_cnt(err_cnt)
   );

   therm2bin_pipe #(.N(8), .ECNT_W(2)) dut_sat (
      .clk(clk), .reset(reset), .din(din2), .din_vld(din2_vld), .din_rdy(din2_rdy),
      .dout(dout2), .dout_err(dout2_err), .dout_vld(dout2_vld), .dout_rdy(dout2_rdy),
      .err_cnt(err_cnt2)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input int act, input int exp);
      nvec++;
      if (act !== exp) begin
         nmis++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic logic [W-1:0] thermo(input int v);
      logic [W-1:0] t;
      t = '0;
      for (int i = 0; i <= v; i++) t[i] = 1'b1;
      return t;
   endfunction

   function automatic vec_t mkvec(input logic [W-1:0] d, input int o, input int e,
                                  input bit lat, input bit gap);
      vec_t v;
      v.din = d; v.dout = o; v.err = e; v.chk_lat = lat; v.chk_gap = gap; v.acc_cyc = 0;
      return v;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_drain();
      int n;
      n = 0;
      while ((tx_q.size() != 0 || exp_q.size() != 0) && n < 100) begin
         tick();
         n++;
      end
      tick();
      if (tx_q.size() != 0 || exp_q.size() != 0) begin
         nvec++;
         nmis++;
         $display("FAIL drain_timeout: got %0d words pending, expected 0", tx_q.size() + exp_q.size());
      end
   endtask

   // Scoreboard and source driver: outputs and inputs are sampled and driven mid-cycle.
   always @(negedge clk) begin
      ncyc++;
      if (reset) begin
         tx_q.delete();
         exp_q.delete();
         exp_cnt = 0;
         din_vld = 1'b0;
      end else begin
         if (dout_vld && dout_rdy) begin
            if (exp_q.size() == 0) begin
               nvec++;
               nmis++;
               $display("FAIL unexpected_out: got dout=%0d, expected no output", dout);
            end else begin
               sb_e = exp_q.pop_front();
               $display("out dout=%0d err=%0b err_cnt=%0d (exp %0d/%0d)", dout, dout_err,
                        err_cnt, sb_e.dout, sb_e.err);
               check("dout", int'(dout), sb_e.dout);
               check("dout_err", int'(dout_err), sb_e.err);
               check("err_cnt", int'(err_cnt), exp_cnt);
               if (sb_e.chk_lat) check("latency", ncyc - sb_e.acc_cyc, 2);
               if (sb_e.chk_gap) check("gap", ncyc - last_out, 1);
               if (sb_e.err != 0 && exp_cnt != 65535) exp_cnt++;
            end
            last_out = ncyc;
         end
         din_vld = (tx_q.size() > 0);
         if (din_vld) din = tx_q[0].din;
         if (din_vld && din_rdy) begin
            sb_e = tx_q.pop_front();
            sb_e.acc_cyc = ncyc;
            exp_q.push_back(sb_e);
            acc_cnt++;
         end
      end
   end

   initial begin
      logic [W-1:0] w;
      int acc0;
      int k;
      bit prev;
      int sat_exp[5];

      din = '0; din_vld = 1'b0; dout_rdy = 1'b1; reset = 1'b1;
      din2 = '0; din2_vld = 1'b0; dout2_rdy = 1'b1;

      tbl[0] = mkvec(thermo(0),   0,   0, 1'b1, 1'b0);
      tbl[1] = mkvec(thermo(37),  37,  0, 1'b1, 1'b0);
      tbl[2] = mkvec(thermo(128), 128, 0, 1'b1, 1'b0);
      tbl[3] = mkvec(thermo(255), 255, 0, 1'b1, 1'b0);
      w = thermo(100); w[50] = 1'b0;
      tbl[4] = mkvec(w, 100, 1, 1'b1, 1'b0);
      w = thermo(20); w[200] = 1'b1;
      tbl[5] = mkvec(w, 20, 1, 1'b1, 1'b0);
      tbl[6] = mkvec('0, 0, 1, 1'b1, 1'b0);
      sat_exp = '{1, 2, 3, 3, 3};

      repeat (3) tick();
      check("rst_dout_vld", int'(dout_vld), 0);
      check("rst_dout", int'(dout), 0);
      check("rst_dout_err", int'(dout_err), 0);
      check("rst_err_cnt", int'(err_cnt), 0);
      reset = 1'b0;
      tick();
      check("din_rdy_after_rst", int'(din_rdy), 1);

      // Clean codes then malformed words, streamed back to back.
      for (int i = 0; i < 7; i++) tx_q.push_back(tbl[i]);
      wait_drain();
      check("err_cnt_after_errors", int'(err_cnt), 3);

      // Backpressure: only two words fit while the sink is stalled.
      acc0 = acc_cnt;
      dout_rdy = 1'b0;
      for (int i = 0; i < 4; i++) begin
         w = thermo(10 * (i + 1));
         tx_q.push_back(mkvec(w, 10 * (i + 1), int'(!is_therm(w)), 1'b0, i != 0));
      end
      repeat (6) tick();
      check("bp_accepted", acc_cnt - acc0, 2);
      check("bp_din_rdy", int'(din_rdy), 0);
      check("bp_dout_vld", int'(dout_vld), 1);
      dout_rdy = 1'b1;
      wait_drain();

      // Reset with both stages full.
      dout_rdy = 1'b0;
      tx_q.push_back(mkvec(thermo(5), 5, 0, 1'b0, 1'b0));
      tx_q.push_back(mkvec(thermo(6), 6, 0, 1'b0, 1'b0));
      repeat (4) tick();
      check("full_din_rdy", int'(din_rdy), 0);
      check("pre_rst_err_cnt", int'(err_cnt), 3);
      @(posedge clk);
      #2;
      reset = 1'b1;
      #1;
      check("async_rst_dout_vld", int'(dout_vld), 0);
      check("async_rst_err_cnt", int'(err_cnt), 0);
      repeat (2) tick();
      reset = 1'b0;
      dout_rdy = 1'b1;
      tx_q.push_back(mkvec(thermo(7), 7, 0, 1'b1, 1'b0));
      wait_drain();
      repeat (4) tick();

      // Saturation on a 2-bit counter.
      k = 0;
      prev = 1'b0;
      for (int c = 0; c < 12; c++) begin
         @(negedge clk);
         if (prev && k < 5) begin
            $display("sat err_cnt=%0d (exp %0d)", err_cnt2, sat_exp[k]);
            check("sat_err_cnt", int'(err_cnt2), sat_exp[k]);
            k++;
         end
         prev = dout2_vld && dout2_rdy;
         din2 = '0;
         din2_vld = (c < 5);
      end
      check("sat_outputs", k, 5);

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
      $finish;
   end

endmodule

// File: doc/therm2bin_pipe.md
Name: therm2bin_pipe

Overview:
- Pipelined thermometer-to-binary encoder; the inverse stage that consumes thermometer words of the form produced by the bin2therm decoder.
- Input thermometer code: bit i = 1 for every i <= value (value 0 → bit 0 only, value 255 → all ones).
- Applies 3-tap majority bubble correction, priority-encodes the highest set bit and flags malformed inputs.
- Valid/ready handshakes on both sides; a saturating error counter is kept for debug visibility.

Parameters:
- N, 8, binary output width.
- W, 2**N, thermometer input width (derived; do not override independently).
- ECNT_W, 16, width of the saturating error counter.

Ports:
- clk  input  1  clock, all state updates on rising edge.
- reset  input  1  asynchronous, active-high reset.
- din  input  W  thermometer word.
- din_vld  input  1  din is valid this cycle.
- din_rdy  output  1  block accepts din this cycle.
- dout  output  N  encoded binary value.
- dout_err  output  1  the input word for this dout was not a clean thermometer code.
- dout_vld  output  1  dout/dout_err are valid.
- dout_rdy  input  1  downstream accepts dout this cycle.
- err_cnt  output  ECNT_W  count of accepted words with dout_err=1, saturating.

Behaviour:
- Reset (async assert, synchronous-to-clk release): both stage valids = 0, dout = 0, dout_err = 0, dout_vld = 0, err_cnt = 0. din_rdy = 1 from the first cycle after reset deasserts.
- Handshake: a transfer occurs on a cycle where vld & rdy are both 1. din_vld may not depend on din_rdy. Data/valid must hold while vld=1 and rdy=0.
- Stage 1 (S1) registers the corrected word and the raw-error flag:
  - corrected[i] = majority(t[i-1], t[i], t[i+1]), with t[-1] = 1 and t[W] = 0 as boundary values.
  - raw_err = 1 if din is not exactly {ones at bits 0..m, zeros above} for some m in 0..W-1. All-zero is an error.
- Stage 2 (S2) registers the output fields:
  - dout = index of the highest set bit of corrected, or 0 if corrected is all zero.
  - dout_err = raw_err.
- Latency: dout_vld is asserted 2 cycles after a din accept when not stalled. Throughput is 1 word/cycle.
- Pipeline advance rules:
  - S2 loads when S1 is valid and (S2 empty or dout_rdy).
  - S1 loads when din accepted.
  - din_rdy = ~S1_vld | S2 loading from S1.
  - No combinational path from dout_rdy to dout_vld. The path dout_rdy → din_rdy is permitted.
- Full condition: both stages valid and dout_rdy=0 → din_rdy=0. No word is dropped or duplicated, and order is preserved.
- Simultaneous events: accept at S1 while S2 drains in the same cycle is legal; full rate is sustained.
- err_cnt increments by 1 on each output transfer (dout_vld & dout_rdy) with dout_err=1. It holds at 2**ECNT_W-1 once reached and never wraps.
- Reset mid-operation: all in-flight words are discarded. No partial output appears after reset.

Decomposition:
- Shared package therm_pkg holds:
  - localparams N and W;
  - a function is_therm(word) used by both RTL and the bench scoreboard.
- One sub-module: therm_bubble_fix. It is purely combinational majority correction plus raw_err generation, reusable for any bin2therm consumer.
- Pipeline control, priority encoder and counter stay in the top module.

Test Plan:
- Clean codes: din = thermometer of 0, 37, 128, 255 back-to-back with dout_rdy=1 → dout = 0, 37, 128, 255 on consecutive cycles, each with dout_err=0. The first appears 2 cycles after the first accept.
- Single bubble: bits 0..100 set with bit 50 cleared → dout=100, dout_err=1, err_cnt=1.
- Isolated high one: bits 0..20 set plus bit 200 → dout=20, dout_err=1. All-zero din → dout=0, dout_err=1. err_cnt increments each time.
- Backpressure: send 4 words with dout_rdy=0 → exactly 2 accepted, din_rdy=0 thereafter. Raise dout_rdy → all 4 emerge in order with no gaps once flowing.
- Saturation: ECNT_W=2, send 5 erroneous words → err_cnt reads 1,2,3,3,3.
- Reset mid-stream: assert reset with both stages full → dout_vld=0 and err_cnt=0 immediately (async). After release, the next word 7 → dout=7 with nothing stale emitted.
